// File: rtl/keypad_code_entry.sv
// Keypad entry stage: assembles four BCD digit presses into a 16-bit code and
// submits it to the lock on ENTER, with CLEAR, overflow and inactivity timeout handling.
module keypad_code_entry #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [15:0] in_code,
    output logic        code_valid,
    output logic        entry_error,
    output logic [2:0]  digit_count
);

    localparam int TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    // The timer holds TIMEOUT_CYCLES-2 on the cycle before the expiring edge.
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 2);

    localparam logic [3:0] KEY_CLEAR = 4'hA;
    localparam logic [3:0] KEY_ENTER = 4'hB;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_PARTIAL,
        ST_FULL,
        ST_OVERFLOW
    } entry_state_t;

    logic [15:0]      code_buf;
    logic             overflow;
    logic [TMR_W-1:0] timer;
    entry_state_t     entry_state;

    always_comb begin
        entry_state = ST_EMPTY;
        if (digit_count == 3'd0)
            entry_state = ST_EMPTY;
        else if (digit_count != 3'd4)
            entry_state = ST_PARTIAL;
        else if (!overflow)
            entry_state = ST_FULL;
        else
            entry_state = ST_OVERFLOW;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            code_buf    <= '0;
            overflow    <= 1'b0;
            timer       <= '0;
            digit_count <= 3'd0;
            in_code     <= '0;
            code_valid  <= 1'b0;
            entry_error <= 1'b0;
        end else begin
            code_valid  <= 1'b0;
            entry_error <= 1'b0;
            if (key_valid) begin
                // Any key, even an ignored code, restarts the inactivity timer.
                timer <= '0;
                if (key_code <= 4'h9) begin
                    case (entry_state)
                        ST_EMPTY, ST_PARTIAL: begin
                            code_buf    <= {code_buf[11:0], key_code};
                            digit_count <= digit_count + 3'd1;
                        end
                        ST_FULL:  overflow <= 1'b1;
                        default:  ;
                    endcase
                end else if (key_code == KEY_CLEAR) begin
                    code_buf    <= '0;
                    overflow    <= 1'b0;
                    digit_count <= 3'd0;
                end else if (key_code == KEY_ENTER) begin
                    if (entry_state == ST_FULL) begin
                        in_code    <= code_buf;
                        code_valid <= 1'b1;
                    end else begin
                        entry_error <= 1'b1;
                    end
                    code_buf    <= '0;
                    overflow    <= 1'b0;
                    digit_count <= 3'd0;
                end
            end else if (entry_state == ST_EMPTY) begin
                timer <= '0;
            end else if (timer == TMR_LAST) begin
                timer       <= '0;
                code_buf    <= '0;
                overflow    <= 1'b0;
                digit_count <= 3'd0;
                entry_error <= 1'b1;
            end else begin
                timer <= timer + 1'b1;
            end
        end
    end

endmodule

// File: doc/keypad_code_entry.md
# keypad_code_entry

Upstream entry stage for the combination lock. Collects single BCD keypresses from the keypad scanner and assembles them into a 4-digit, 16-bit code, first digit in the most significant nibble. Presents the code to the lock with a one-cycle `code_valid` strobe when ENTER is pressed. Handles CLEAR, malformed entries and an inter-key timeout, so the lock only ever evaluates complete 4-digit codes.

## Interface
- `TIMEOUT_CYCLES`, default 1000: clock cycles of keypad inactivity, while a partial entry exists, before the entry is abandoned. Must be ≥ 2.
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `key_valid`, input, 1: one-cycle strobe; `key_code` is valid in that cycle.
- `key_code`, input, 4: 0x0–0x9 are digits; 0xA is CLEAR; 0xB is ENTER; 0xC–0xF are ignored.
- `in_code`, output, 16: last submitted code, 4 BCD nibbles, first-entered digit in [15:12]. Held until the next successful submission.
- `code_valid`, output, 1: one-cycle pulse when `in_code` has just been updated.
- `entry_error`, output, 1: one-cycle pulse on a rejected ENTER or on a timeout.
- `digit_count`, output, 3: digits currently buffered, 0–4.

## Operation
- Internal state:
  - 16-bit shift buffer `buf`.
  - `digit_count`.
  - `overflow` flag.
  - Inactivity timer, ceil(log2(TIMEOUT_CYCLES)) bits.
- Entry states, derived from count and overflow:
  - EMPTY: count 0.
  - PARTIAL: count 1–3.
  - FULL: count 4, overflow 0.
  - OVERFLOW: count 4, overflow 1.
- Digit keypress:
  - EMPTY or PARTIAL: `buf <= {buf[11:0], key_code}`, count +1.
  - FULL: buffer unchanged, overflow set, go to OVERFLOW.
  - OVERFLOW: no change.
- ENTER:
  - In FULL: `in_code <= buf`, `code_valid` pulses, and buf, count and overflow clear to EMPTY.
  - In any other state, including EMPTY: `entry_error` pulses, state clears to EMPTY, and `in_code` is unchanged.
- CLEAR: clears to EMPTY from any state. No pulse on either output.
- Keys 0xC–0xF: no state change, but they still restart the inactivity timer.
- Timer behaviour:
  - Held at 0 in EMPTY.
  - Otherwise increments each cycle with no `key_valid`.
  - Any `key_valid` resets it to 0.
  - When it reaches TIMEOUT_CYCLES−1 with no `key_valid` in that cycle, state clears to EMPTY and `entry_error` pulses.
- A timeout and a `key_valid` in the same cycle: the key wins. The key is processed against the current buffer, the timer restarts, and no timeout error is raised.
- `code_valid` and `entry_error` are never high in the same cycle.

## Timing
- All outputs are registered. For a `key_valid` sampled at edge k, the updated `in_code`, `code_valid`, `entry_error` and `digit_count` are visible after edge k, for exactly one cycle in the case of the pulses.
- ENTER-to-`code_valid` latency is 1 edge. No back-pressure: the lock consumes the code in the strobe cycle.
- Back-to-back keys on consecutive cycles are all accepted. There is no minimum gap.
- Timeout fires at edge N+TIMEOUT_CYCLES−1, where edge N is the last key edge. `entry_error` is visible after that edge.
- Asynchronous reset, mid-entry or otherwise:
  - `in_code` = 16'h0000, `code_valid` = 0, `entry_error` = 0, `digit_count` = 0.
  - buf = 0, overflow = 0, timer = 0.
  - No pulse is emitted on reset deassertion.
- Reset deassertion is synchronised externally. The first key is accepted on the first edge after `reset_n` goes high.

## Test plan
- Keys 1, 4, 7, 3, ENTER on consecutive cycles -> `digit_count` steps 1, 2, 3, 4, 0; `in_code` = 16'h1473 with `code_valid` high for one cycle after the ENTER edge; `entry_error` stays 0.
- Keys 1, 4, ENTER -> `entry_error` pulses once, `code_valid` stays 0, `in_code` keeps its prior value, `digit_count` = 0.
- Keys 1, 4, 7, 3, 9, ENTER -> overflow; `entry_error` pulses and there is no `code_valid`. Then keys 2, 1, 8, 9, ENTER -> `in_code` = 16'h2189 with `code_valid`.
- With TIMEOUT_CYCLES = 8: key 5, then idle -> `entry_error` pulses exactly 7 edges after the key edge and `digit_count` returns to 0. Repeat with a key 0xC on edge 6 -> no timeout at edge 7.
- Keys 1, 4, CLEAR, 1, 4, 7, 3, ENTER -> no pulse at CLEAR; `in_code` = 16'h1473 with `code_valid`.
- Keys 1, 4, 7, then `reset_n` low for 3 cycles mid-entry -> all outputs 0 immediately, asynchronously. After release, 1, 4, 7, 3, ENTER -> 16'h1473 submitted.
